load_store_buffer: RTL and testbench

In-order load/store queue between the dispatch/ROB logic and the unified `Cache` data port. Holds up to `2**LSB_WIDTH` memory operations and issues them one at a time to the cache. Stores issue only after the ROB commits them. Load results are sign- or zero-extended and broadcast with their ROB index. On `clearIn`, every uncommitted entry is discarded.

---
 rtl/load_store_buffer.sv | 130 +++++++++++++
 tb/tb_load_store_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order load/store queue feeding the unified cache data port.
// Define LSB_MMIO_GUARD_EN to hold I/O-space loads (addr[17:16]==2'b11) until their ROB entry reaches commit.
module load_store_buffer #(
    parameter int LSB_WIDTH = 3,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clkIn,
    input  logic                 resetIn,
    input  logic                 clearIn,
    input  logic                 readyIn,
    input  logic                 issueValid,
    input  logic [2:0]           issueFunct3,
    input  logic                 issueWrite,
    input  logic [31:0]          issueAddr,
    input  logic [31:0]          issueData,
    input  logic [ROB_WIDTH-1:0] issueRobIndex,
    input  logic [ROB_WIDTH-1:0] robHeadIndex,
    input  logic                 commitStore,
    output logic                 full,
    output logic [1:0]           accessType,
    output logic                 readWriteOut,
    output logic [31:0]          dataAddrOut,
    output logic [31:0]          dataOut,
    input  logic                 dataInValid,
    input  logic [31:0]          dataIn,
    input  logic                 dataWriteSuc,
    output logic                 resultValid,
    output logic [ROB_WIDTH-1:0] resultRobIndex,
    output logic [31:0]          resultValue
);
    localparam int DEPTH = 1 << LSB_WIDTH;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} lsbState;
    lsbState state, nextState;
    logic [2:0]           entFunct3 [DEPTH];
    logic                 entWrite  [DEPTH];
    logic [31:0]          entAddr   [DEPTH];
    logic [31:0]          entData   [DEPTH];
    logic [ROB_WIDTH-1:0] entRob    [DEPTH];
    logic [LSB_WIDTH-1:0] head, tail, headNext;
    logic [LSB_WIDTH:0]   count, committedCount, ccNext;
    logic [2:0]           headFunct3;
    logic                 headWrite;
    logic [31:0]          headAddr, headData, loadValue;
    logic [ROB_WIDTH-1:0] headRob;
    logic                 enq, popStore, popLoad, pop, eligible, loadOk;

    assign headFunct3 = entFunct3[head];
    assign headWrite  = entWrite[head];
    assign headAddr   = entAddr[head];
    assign headData   = entData[head];
    assign headRob    = entRob[head];

    // count never exceeds DEPTH, so its top bit alone marks a full queue
    assign full = count[LSB_WIDTH];
    assign enq = issueValid && !full && readyIn && !clearIn;

`ifdef LSB_MMIO_GUARD_EN
    assign loadOk = headAddr[17:16] != 2'b11 || headRob == robHeadIndex;
`else
    logic unusedRobHead;
    assign unusedRobHead = ^robHeadIndex;
    assign loadOk = 1'b1;
`endif

    // committed stores sit contiguously at head, so a nonzero committedCount means head is one
    assign eligible = count != '0 && (headWrite ? committedCount != '0 : loadOk);
    assign popStore = state == WAIT && headWrite && dataWriteSuc;
    assign popLoad  = state == WAIT && !headWrite && dataInValid && !clearIn;
    assign pop      = popStore || popLoad;
    assign headNext = head + LSB_WIDTH'(pop);
    assign ccNext   = committedCount + (LSB_WIDTH+1)'(commitStore) - (LSB_WIDTH+1)'(popStore);

    assign loadValue = headFunct3[1:0] == 2'b00 ? {{24{!headFunct3[2] && dataIn[7]}}, dataIn[7:0]} :
                       headFunct3[1:0] == 2'b01 ? {{16{!headFunct3[2] && dataIn[15]}}, dataIn[15:0]} :
                       dataIn;

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    nextState = eligible && readyIn && !clearIn ? REQ : IDLE;
            REQ:     nextState = clearIn && !headWrite ? IDLE : WAIT;
            WAIT:    nextState = pop || (clearIn && !headWrite) ? IDLE : WAIT;
            default: nextState = IDLE;
        endcase
    end

    assign accessType   = state == REQ ? headFunct3[1:0] + 2'd1 : 2'b00;
    assign readWriteOut = state == REQ ? !headWrite : 1'b1;
    assign dataAddrOut  = state == REQ ? headAddr : '0;
    assign dataOut      = state == REQ ? headData : '0;

    always_ff @(posedge clkIn) begin
        if (!resetIn)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            committedCount <= '0;
            resultValid    <= 1'b0;
            resultRobIndex <= '0;
            resultValue    <= '0;
        end else begin
            head           <= headNext;
            committedCount <= ccNext;
            tail           <= clearIn ? headNext + ccNext[LSB_WIDTH-1:0] : tail + LSB_WIDTH'(enq);
            count          <= clearIn ? ccNext : count + (LSB_WIDTH+1)'(enq) - (LSB_WIDTH+1)'(pop);
            resultValid    <= popLoad;
            if (popLoad) begin
                resultRobIndex <= headRob;
                resultValue    <= loadValue;
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (enq) begin
            entFunct3[tail] <= issueFunct3;
            entWrite[tail]  <= issueWrite;
            entAddr[tail]   <= issueAddr;
            entData[tail]   <= issueData;
            entRob[tail]    <= issueRobIndex;
        end
    end
endmodule

// File: tb/tb_load_store_buffer.sv
// tb_load_store_buffer: directed vectors and hand-written sequences for load_store_buffer.
module tb_load_store_buffer;
    logic        clkIn = 1'b0;
    logic        resetIn, clearIn, readyIn, issueValid, issueWrite, commitStore;
    logic [2:0]  issueFunct3;
    logic [31:0] issueAddr, issueData, dataAddrOut, dataOut, dataIn, resultValue;
    logic [3:0]  issueRobIndex, robHeadIndex, resultRobIndex;
    logic        full, readWriteOut, dataInValid, dataWriteSuc, resultValid;
    logic [1:0]  accessType;
    int applied = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [3:0]  rob;
        logic [31:0] rdata;
        int          lat;
        logic [1:0]  expAcc;
        logic [31:0] expVal;
    } loadVec;
    loadVec vecs[6];
    loadVec extra;

    always #5 clkIn = ~clkIn;

    load_store_buffer #(.LSB_WIDTH(3), .ROB_WIDTH(4)) dut (
        .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn), .readyIn(readyIn),
        .issueValid(issueValid), .issueFunct3(issueFunct3), .issueWrite(issueWrite),
        .issueAddr(issueAddr), .issueData(issueData), .issueRobIndex(issueRobIndex),
        .robHeadIndex(robHeadIndex), .commitStore(commitStore), .full(full),
        .accessType(accessType), .readWriteOut(readWriteOut), .dataAddrOut(dataAddrOut),
        .dataOut(dataOut), .dataInValid(dataInValid), .dataIn(dataIn),
        .dataWriteSuc(dataWriteSuc), .resultValid(resultValid),
        .resultRobIndex(resultRobIndex), .resultValue(resultValue)
    );

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] rob);
        issueValid = 1'b1; issueFunct3 = f3; issueWrite = wr;
        issueAddr = addr; issueData = data; issueRobIndex = rob;
        tick();
        issueValid = 1'b0;
    endtask

    task automatic commit();
        commitStore = 1'b1;
        tick();
        commitStore = 1'b0;
    endtask

    task automatic storeTxn(input logic [1:0] acc, input logic [31:0] addr, input logic [31:0] data);
        commit();
        check("st idle", 32'(accessType), 32'h0);
        tick();
        check("st acc", 32'(accessType), 32'(acc));
        check("st rw", 32'(readWriteOut), 32'h0);
        check("st addr", dataAddrOut, addr);
        check("st data", dataOut, data);
        tick();
        dataWriteSuc = 1'b1;
        tick();
        dataWriteSuc = 1'b0;
    endtask

    task automatic doLoad(input loadVec v);
        issue(v.f3, 1'b0, v.addr, 32'h0, v.rob);
        check("ld idle", 32'(accessType), 32'h0);
        tick();
        check("ld acc", 32'(accessType), 32'(v.expAcc));
        check("ld rw", 32'(readWriteOut), 32'h1);
        check("ld addr", dataAddrOut, v.addr);
        tick();
        check("ld wait acc", 32'(accessType), 32'h0);
        repeat (v.lat) tick();
        dataIn = v.rdata; dataInValid = 1'b1;
        tick();
        dataInValid = 1'b0;
        check("ld valid", 32'(resultValid), 32'h1);
        check("ld rob", 32'(resultRobIndex), 32'(v.rob));
        check("ld value", resultValue, v.expVal);
        tick();
        check("ld pulse end", 32'(resultValid), 32'h0);
    endtask

    initial begin
        vecs[0] = '{3'b010, 32'h0000_1000, 4'd3, 32'hDEAD_BEEF, 2, 2'b11, 32'hDEAD_BEEF};
        vecs[1] = '{3'b000, 32'h0000_1001, 4'd1, 32'h0000_0080, 0, 2'b01, 32'hFFFF_FF80};
        vecs[2] = '{3'b100, 32'h0000_1002, 4'd2, 32'h0000_0080, 1, 2'b01, 32'h0000_0080};
        vecs[3] = '{3'b001, 32'h0000_1004, 4'd4, 32'h0000_F00F, 0, 2'b10, 32'hFFFF_F00F};
        vecs[4] = '{3'b101, 32'h0000_1006, 4'd6, 32'h0000_F00F, 3, 2'b10, 32'h0000_F00F};
        vecs[5] = '{3'b000, 32'h0000_1007, 4'd7, 32'hFFFF_FF7F, 0, 2'b01, 32'h0000_007F};

        resetIn = 1'b0; clearIn = 1'b0; readyIn = 1'b1; issueValid = 1'b0; issueWrite = 1'b0;
        commitStore = 1'b0; issueFunct3 = 3'b0; issueAddr = 32'h0; issueData = 32'h0;
        issueRobIndex = 4'h0; robHeadIndex = 4'h0; dataInValid = 1'b0; dataIn = 32'h0;
        dataWriteSuc = 1'b0;
        repeat (2) tick();
        check("rst full", 32'(full), 32'h0);
        check("rst acc", 32'(accessType), 32'h0);
        check("rst rw", 32'(readWriteOut), 32'h1);
        check("rst addr", dataAddrOut, 32'h0);
        check("rst data", dataOut, 32'h0);
        check("rst valid", 32'(resultValid), 32'h0);
        check("rst rob", 32'(resultRobIndex), 32'h0);
        check("rst value", resultValue, 32'h0);
        resetIn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) doLoad(vecs[i]);

        // store waits for commit
        issue(3'b010, 1'b1, 32'h2000, 32'h1234_5678, 4'd7);
        repeat (3) begin
            check("st uncommitted", 32'(accessType), 32'h0);
            tick();
        end
        storeTxn(2'b11, 32'h2000, 32'h1234_5678);
        check("st freed", 32'(full), 32'h0);

        // fill, overflow, pop+enqueue, wrap ordering
        for (int i = 0; i < 8; i++) issue(3'b010, 1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'(i));
        check("fill full", 32'(full), 32'h1);
        issue(3'b010, 1'b1, 32'h999, 32'h999, 4'd15);
        check("overflow full", 32'(full), 32'h1);
        storeTxn(2'b11, 32'h100, 32'hA0);
        check("after pop", 32'(full), 32'h0);
        commit();
        tick();
        check("pe addr", dataAddrOut, 32'h104);
        tick();
        dataWriteSuc = 1'b1;
        issueValid = 1'b1; issueFunct3 = 3'b010; issueWrite = 1'b1;
        issueAddr = 32'h120; issueData = 32'hA8; issueRobIndex = 4'd8;
        tick();
        dataWriteSuc = 1'b0; issueValid = 1'b0;
        check("pop+enq count", 32'(full), 32'h0);
        issue(3'b010, 1'b1, 32'h124, 32'hA9, 4'd9);
        check("refill full", 32'(full), 32'h1);
        for (int i = 2; i < 10; i++) storeTxn(2'b11, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        check("drained", 32'(full), 32'h0);

        // flush with committed SB in flight, uncommitted SW and LW behind
        issue(3'b000, 1'b1, 32'h3003, 32'h0000_00FF, 4'd8);
        issue(3'b010, 1'b1, 32'h3004, 32'h5555_5555, 4'd9);
        issue(3'b010, 1'b0, 32'h3008, 32'h0, 4'd10);
        commit();
        tick();
        check("fl sb acc", 32'(accessType), 32'h1);
        check("fl sb addr", dataAddrOut, 32'h3003);
        tick();
        clearIn = 1'b1;
        tick();
        clearIn = 1'b0;
        check("fl wait acc", 32'(accessType), 32'h0);
        tick();
        dataWriteSuc = 1'b1;
        tick();
        dataWriteSuc = 1'b0;
        check("fl no result", 32'(resultValid), 32'h0);
        check("fl full", 32'(full), 32'h0);
        repeat (3) begin
            tick();
            check("fl discarded", 32'(accessType), 32'h0);
        end
        extra = '{3'b010, 32'h4000, 4'd11, 32'h0BAD_F00D, 0, 2'b11, 32'h0BAD_F00D};
        doLoad(extra);

        // flush drops an in-flight load even with a simultaneous response
        issue(3'b010, 1'b0, 32'h5000, 32'h0, 4'd12);
        tick();
        tick();
        clearIn = 1'b1; dataInValid = 1'b1; dataIn = 32'h1234;
        tick();
        clearIn = 1'b0; dataInValid = 1'b0;
        check("ldfl valid", 32'(resultValid), 32'h0);
        tick();
        check("ldfl acc", 32'(accessType), 32'h0);
        check("ldfl valid2", 32'(resultValid), 32'h0);

        // commit together with clear keeps the store
        issue(3'b010, 1'b1, 32'h6000, 32'h66, 4'd13);
        commitStore = 1'b1; clearIn = 1'b1;
        tick();
        commitStore = 1'b0; clearIn = 1'b0;
        check("cc idle", 32'(accessType), 32'h0);
        tick();
        check("cc acc", 32'(accessType), 32'h3);
        check("cc addr", dataAddrOut, 32'h6000);
        tick();
        dataWriteSuc = 1'b1;
        tick();
        dataWriteSuc = 1'b0;

        // readyIn low blocks acceptance
        readyIn = 1'b0;
        issue(3'b010, 1'b0, 32'h8000, 32'h0, 4'd1);
        tick();
        readyIn = 1'b1;
        repeat (2) begin
            tick();
            check("notready acc", 32'(accessType), 32'h0);
        end

        // I/O-space load
        robHeadIndex = 4'd2;
        issue(3'b010, 1'b0, 32'h3_0000, 32'h0, 4'd5);
`ifdef LSB_MMIO_GUARD_EN
        repeat (3) begin
            check("mmio held", 32'(accessType), 32'h0);
            tick();
        end
        robHeadIndex = 4'd5;
        tick();
`else
        tick();
`endif
        check("mmio acc", 32'(accessType), 32'h3);
        check("mmio addr", dataAddrOut, 32'h3_0000);
        tick();
        dataIn = 32'hCAFE_0001; dataInValid = 1'b1;
        tick();
        dataInValid = 1'b0;
        check("mmio valid", 32'(resultValid), 32'h1);
        check("mmio rob", 32'(resultRobIndex), 32'h5);
        check("mmio value", resultValue, 32'hCAFE_0001);
        tick();

        // reset mid-transaction abandons the load
        issue(3'b010, 1'b0, 32'h7000, 32'h0, 4'd14);
        tick();
        tick();
        resetIn = 1'b0;
        tick();
        resetIn = 1'b1; dataInValid = 1'b1;
        tick();
        dataInValid = 1'b0;
        check("mid rst valid", 32'(resultValid), 32'h0);
        check("mid rst acc", 32'(accessType), 32'h0);
        check("mid rst full", 32'(full), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
